// File: rtl/mem_port_arbiter.sv
// Shared memory bus arbiter between instruction fetch (IF) and load/store (MEM).
// Serialises one bus transaction at a time. MEM has priority, and a bounded
// streak counter lets a waiting fetch win after MAX_MEM_STREAK MEM grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // fetch port
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_flush_i,
  output logic                    if_done_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_stall_o,
  // load/store port
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_be_i,
  output logic                    mem_done_o,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_stall_o,
  // shared bus
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  input  logic                    bus_gnt_i,
  input  logic                    bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i
);

  localparam int unsigned BE_WIDTH     = DATA_WIDTH / 8;
  localparam int unsigned STREAK_WIDTH = $clog2(MAX_MEM_STREAK + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  logic [1:0]              state_q,  state_d;
  logic                    owner_q,  owner_d;
  logic                    killed_q, killed_d;
  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic                    bus_req_q,   bus_req_d;
  logic                    bus_we_q,    bus_we_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q,  bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic [BE_WIDTH-1:0]     bus_be_q,    bus_be_d;

  logic if_elig;
  logic streak_full;
  logic mem_wins;
  logic if_wins;
  logic rsp_valid;

  // Arbitration terms; a flushed fetch is not eligible to win.
  always_comb begin
    if_elig     = if_req_i & ~if_flush_i;
    streak_full = (streak_q == STREAK_WIDTH'(MAX_MEM_STREAK));
    mem_wins    = mem_req_i & ~(streak_full & if_elig);
    if_wins     = if_elig & ~mem_wins;
    rsp_valid   = (state_q == S_WAIT) & bus_rvalid_i;
  end

  // Next-state and bus command logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    killed_d    = killed_q;
    streak_d    = streak_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;

    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        streak_d = (mem_wins & if_elig) ? streak_q + STREAK_WIDTH'(1) : '0;
        if (mem_wins) begin
          state_d     = S_REQ;
          owner_d     = OWNER_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_be_d    = mem_be_i;
        end else if (if_wins) begin
          state_d    = S_REQ;
          owner_d    = OWNER_IF;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr_i;
          bus_be_d   = '1;
        end
      end
      S_REQ: begin
        if ((owner_q == OWNER_IF) && if_flush_i) killed_d = 1'b1;
        if (bus_gnt_i) begin
          state_d   = S_WAIT;
          bus_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        if ((owner_q == OWNER_IF) && if_flush_i) killed_d = 1'b1;
        if (bus_rvalid_i) begin
          state_d  = S_IDLE;
          killed_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and bus command registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWNER_IF;
      killed_q    <= 1'b0;
      streak_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      killed_q    <= killed_d;
      streak_q    <= streak_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  // Completion pulses follow the response strobe in the same cycle; a killed
  // or concurrently flushed fetch response is dropped.
  always_comb begin
    mem_done_o  = rsp_valid & (owner_q == OWNER_MEM);
    if_done_o   = rsp_valid & (owner_q == OWNER_IF) & ~killed_q & ~if_flush_i;
    mem_rdata_o = bus_rdata_i;
    if_rdata_o  = bus_rdata_i;
    mem_stall_o = mem_req_i & ~mem_done_o;
    if_stall_o  = if_req_i & ~if_done_o;
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned MAX = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req_i, if_flush_i;
  logic [AW-1:0] if_addr_i;
  logic          if_done_o, if_stall_o;
  logic [DW-1:0] if_rdata_o;
  logic          mem_req_i, mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [BW-1:0] mem_be_i;
  logic          mem_done_o, mem_stall_o;
  logic [DW-1:0] mem_rdata_o;
  logic          bus_req_o, bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [BW-1:0] bus_be_o;
  logic          bus_gnt_i, bus_rvalid_i;
  logic [DW-1:0] bus_rdata_i;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_MEM_STREAK(MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o), .mem_stall_o(mem_stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: which port owns the one outstanding bus
  // transaction, whether it is still waiting for acceptance or for its
  // response, and how many MEM grants in a row have passed a waiting fetch.
  int            outstanding;   // 0 none, 1 awaiting accept, 2 awaiting response
  logic          owner_is_mem;
  logic          fetch_dropped;
  int            mem_run;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [BW-1:0] e_be;

  // Requester-side bookkeeping.
  logic if_hold, mem_hold;
  logic prev_if_done, prev_mem_done, prev_flush;
  int   if_grants, mem_grants;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the rules of the arbiter to the inputs present at the edge just taken.
  task automatic model_edge();
    logic fetch_ok;
    if (!rst_n) begin
      outstanding   = 0;
      owner_is_mem  = 1'b0;
      fetch_dropped = 1'b0;
      mem_run       = 0;
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    end else if (outstanding == 0) begin
      fetch_ok = if_req_i && !if_flush_i;
      if (mem_req_i && !(fetch_ok && mem_run == int'(MAX))) begin
        outstanding  = 1;
        owner_is_mem = 1'b1;
        e_we = mem_we_i; e_addr = mem_addr_i; e_wdata = mem_wdata_i; e_be = mem_be_i;
        mem_run = fetch_ok ? mem_run + 1 : 0;
        mem_grants++;
      end else begin
        mem_run = 0;
        if (fetch_ok) begin
          outstanding  = 1;
          owner_is_mem = 1'b0;
          e_we = 1'b0; e_addr = if_addr_i; e_be = '1;
          if_grants++;
        end
      end
    end else begin
      if (!owner_is_mem && if_flush_i) fetch_dropped = 1'b1;
      if (outstanding == 1 && bus_gnt_i) outstanding = 2;
      else if (outstanding == 2 && bus_rvalid_i) begin
        outstanding   = 0;
        fetch_dropped = 1'b0;
      end
    end
  endtask

  // One clock cycle: update the model, check the bus command, drive new
  // inputs, then check the same-cycle completion and stall outputs.
  task automatic step(input int mem_pct, input int if_pct, input int gnt_pct,
                      input int rv_pct, input int flush_pct, input int rst_permil,
                      input bit force_rst);
    logic e_idone, e_mdone;
    @(posedge clk);
    #1;
    model_edge();
    check("bus_req",   64'(bus_req_o),   64'(outstanding == 1));
    check("bus_we",    64'(bus_we_o),    64'(e_we));
    check("bus_addr",  64'(bus_addr_o),  64'(e_addr));
    check("bus_wdata", 64'(bus_wdata_o), 64'(e_wdata));
    check("bus_be",    64'(bus_be_o),    64'(e_be));

    if (prev_if_done || prev_flush) if_hold = 1'b0;
    if (prev_mem_done) mem_hold = 1'b0;
    rst_n = !(force_rst || int'($urandom_range(999)) < rst_permil);
    if (!rst_n) begin
      if_hold = 1'b0; mem_hold = 1'b0;
    end else begin
      if (!if_hold && int'($urandom_range(99)) < if_pct) begin
        if_hold   = 1'b1;
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!mem_hold && int'($urandom_range(99)) < mem_pct) begin
        mem_hold    = 1'b1;
        mem_we_i    = 1'($urandom);
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
        mem_be_i    = BW'($urandom);
      end
    end
    if_req_i     = if_hold;
    mem_req_i    = mem_hold;
    if_flush_i   = rst_n && int'($urandom_range(99)) < flush_pct;
    bus_gnt_i    = int'($urandom_range(99)) < gnt_pct;
    bus_rvalid_i = rst_n && ((outstanding == 2) ? int'($urandom_range(99)) < rv_pct
                                                : $urandom_range(99) < 3);
    bus_rdata_i  = $urandom;

    #1;
    e_mdone = (outstanding == 2) && owner_is_mem && bus_rvalid_i;
    e_idone = (outstanding == 2) && !owner_is_mem && !fetch_dropped && !if_flush_i
              && bus_rvalid_i;
    check("mem_done",  64'(mem_done_o),  64'(e_mdone));
    check("if_done",   64'(if_done_o),   64'(e_idone));
    check("mem_stall", 64'(mem_stall_o), 64'(mem_req_i && !e_mdone));
    check("if_stall",  64'(if_stall_o),  64'(if_req_i && !e_idone));
    if (e_mdone) check("mem_rdata", 64'(mem_rdata_o), 64'(bus_rdata_i));
    if (e_idone) check("if_rdata",  64'(if_rdata_o),  64'(bus_rdata_i));
    prev_if_done  = e_idone;
    prev_mem_done = e_mdone;
    prev_flush    = if_flush_i;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    if_hold = 1'b0; mem_hold = 1'b0;
    prev_if_done = 1'b0; prev_mem_done = 1'b0; prev_flush = 1'b0;
    outstanding = 0; owner_is_mem = 1'b0; fetch_dropped = 1'b0; mem_run = 0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    if_grants = 0; mem_grants = 0;

    for (int i = 0; i < 3; i++) step(0, 0, 50, 50, 0, 0, 1'b1);
    // Heavy MEM traffic with waiting fetches: exercises the streak limit.
    for (int i = 0; i < 800; i++) step(90, 50, 60, 60, 3, 5, 1'b0);
    // Slow bus with frequent flushes: delayed grants and killed fetches.
    for (int i = 0; i < 800; i++) step(30, 70, 30, 40, 10, 5, 1'b0);
    // Saturated bus: both ports always requesting at full throughput.
    for (int i = 0; i < 800; i++) step(100, 100, 100, 100, 0, 2, 1'b0);
    // Fetch-only, then MEM-only traffic.
    for (int i = 0; i < 300; i++) step(0, 80, 70, 70, 5, 3, 1'b0);
    for (int i = 0; i < 300; i++) step(80, 0, 70, 70, 5, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
